// File: rtl/pe_data_processor.sv
// Query/target sequence store and pass-to-pass writeback ping-pong for the PE array.
// Heads are combinational from registered pointers; a consume is visible the next cycle, and reads stall until writeback catches up.
module pe_data_processor #(
  parameter int VEF_BIT    = 16,
  parameter int S_ADDR_BIT = 10,
  parameter int T_ADDR_BIT = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load_valid,
  input  logic               i_load_sel,
  input  logic [1:0]         i_load_data,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overrun,
  output logic               o_data_valid,
  input  logic               i_update_s,
  output logic [1:0]         o_s,
  output logic               o_s_last,
  input  logic               i_update_t,
  output logic [1:0]         o_t,
  output logic [VEF_BIT-1:0] o_v,
  output logic [VEF_BIT-1:0] o_f,
  output logic               o_t_last,
  input  logic               i_t_valid,
  input  logic [1:0]         i_t,
  input  logic [VEF_BIT-1:0] i_v,
  input  logic [VEF_BIT-1:0] i_f
);

  localparam int S_DEPTH = 1 << S_ADDR_BIT;
  localparam int T_DEPTH = 1 << T_ADDR_BIT;
  localparam int WB_W    = 2 + 2 * VEF_BIT;

  localparam logic [S_ADDR_BIT:0]   S_ONE  = {{S_ADDR_BIT{1'b0}}, 1'b1};
  localparam logic [T_ADDR_BIT:0]   T_ONE  = {{T_ADDR_BIT{1'b0}}, 1'b1};
  localparam logic [S_ADDR_BIT-1:0] P_ONE  = {{(S_ADDR_BIT-1){1'b0}}, 1'b1};
  localparam logic [S_ADDR_BIT:0]   S_FULL = {1'b1, {S_ADDR_BIT{1'b0}}};
  localparam logic [T_ADDR_BIT:0]   T_FULL = {1'b1, {T_ADDR_BIT{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_LAST_T, ST_END} state_t;

  state_t                state;
  logic [S_ADDR_BIT:0]   s_len, s_ptr;
  logic [T_ADDR_BIT:0]   t_len, t_ptr, wr_cnt;
  logic [S_ADDR_BIT-1:0] rd_pass, wr_pass;
  logic                  s_reload, t_reload;

  logic [1:0]      s_mem  [S_DEPTH];
  logic [1:0]      t_mem  [T_DEPTH];
  logic [WB_W-1:0] wb_mem [2*T_DEPTH];

  logic [S_ADDR_BIT:0]   s_ld_idx;
  logic [T_ADDR_BIT:0]   t_ld_idx;
  logic                  s_wr, t_wr;
  logic                  active, pass0, valid_c;
  logic [S_ADDR_BIT-1:0] rd_prev;
  logic [WB_W-1:0]       wb_rd;
  logic                  s_last_c, t_last_c, s_fire, t_fire;
  logic                  wb_req, wb_ovr, wb_wr, wb_wr_end;

  // Pass counters wrap, so "a is ahead of b" means a nonzero difference within the lower half-range.
  function automatic logic pass_gt(input logic [S_ADDR_BIT-1:0] a, input logic [S_ADDR_BIT-1:0] b);
    logic [S_ADDR_BIT-1:0] d;
    d = a - b;
    return (d != '0) && !d[S_ADDR_BIT-1];
  endfunction

  // The first load after a completed run restarts that sequence from index 0.
  assign s_ld_idx = s_reload ? '0 : s_len;
  assign t_ld_idx = t_reload ? '0 : t_len;
  assign s_wr = (state == ST_IDLE) && i_load_valid && !i_load_sel && (s_ld_idx != S_FULL);
  assign t_wr = (state == ST_IDLE) && i_load_valid &&  i_load_sel && (t_ld_idx != T_FULL);

  assign active  = (state == ST_RUN) || (state == ST_LAST_T);
  assign pass0   = (rd_pass == '0);
  assign rd_prev = rd_pass - P_ONE;
  assign wb_rd   = wb_mem[{rd_prev[0], t_ptr[T_ADDR_BIT-1:0]}];
  assign valid_c = active && (pass0 || pass_gt(wr_pass, rd_prev) ||
                              ((wr_pass == rd_prev) && (wr_cnt > t_ptr)));

  assign s_last_c = (s_ptr == s_len - S_ONE);
  assign t_last_c = (t_ptr == t_len - T_ONE);
  assign s_fire   = i_update_s && valid_c && (state == ST_RUN);
  assign t_fire   = i_update_t && valid_c;

  assign wb_req    = active && i_t_valid;
  assign wb_ovr    = wb_req && pass_gt(wr_pass, rd_pass);
  assign wb_wr     = wb_req && !wb_ovr;
  assign wb_wr_end = (wr_cnt == t_len - T_ONE);

  always_comb begin
    o_data_valid = valid_c;
    o_s          = '0;
    o_s_last     = 1'b0;
    o_t          = '0;
    o_v          = '0;
    o_f          = '0;
    o_t_last     = 1'b0;
    if (valid_c) begin
      o_s      = s_mem[s_ptr[S_ADDR_BIT-1:0]];
      o_s_last = s_last_c;
      o_t_last = t_last_c;
      if (pass0) begin
        o_t = t_mem[t_ptr[T_ADDR_BIT-1:0]];
      end else begin
        {o_t, o_v, o_f} = wb_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_wr) s_mem[s_ld_idx[S_ADDR_BIT-1:0]] <= i_load_data;
    if (t_wr) t_mem[t_ld_idx[T_ADDR_BIT-1:0]] <= i_load_data;
    if (wb_wr) wb_mem[{wr_pass[0], wr_cnt[T_ADDR_BIT-1:0]}] <= {i_t, i_v, i_f};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s_len     <= '0;
      t_len     <= '0;
      s_ptr     <= '0;
      t_ptr     <= '0;
      wr_cnt    <= '0;
      rd_pass   <= '0;
      wr_pass   <= '0;
      s_reload  <= 1'b0;
      t_reload  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_wr) begin
            s_len    <= s_ld_idx + S_ONE;
            s_reload <= 1'b0;
          end
          if (t_wr) begin
            t_len    <= t_ld_idx + T_ONE;
            t_reload <= 1'b0;
          end
          if (i_start && (s_len != '0) && (t_len != '0)) begin
            state   <= ST_RUN;
            o_busy  <= 1'b1;
            s_ptr   <= '0;
            t_ptr   <= '0;
            wr_cnt  <= '0;
            rd_pass <= '0;
            wr_pass <= '0;
          end
        end
        ST_RUN, ST_LAST_T: begin
          if (s_fire) begin
            if (s_last_c) state <= ST_LAST_T;
            else          s_ptr <= s_ptr + S_ONE;
          end
          if (t_fire) begin
            if (t_last_c) begin
              t_ptr   <= '0;
              rd_pass <= rd_pass + P_ONE;
              if (state == ST_LAST_T) begin
                state  <= ST_END;
                o_done <= 1'b1;
              end
            end else begin
              t_ptr <= t_ptr + T_ONE;
            end
          end
          if (wb_ovr) o_overrun <= 1'b1;
          if (wb_wr) begin
            if (wb_wr_end) begin
              wr_cnt  <= '0;
              wr_pass <= wr_pass + P_ONE;
            end else begin
              wr_cnt <= wr_cnt + T_ONE;
            end
          end
        end
        ST_END: begin
          state    <= ST_IDLE;
          o_busy   <= 1'b0;
          o_done   <= 1'b0;
          s_reload <= 1'b1;
          t_reload <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_data_processor.md
Name: pe_data_processor

Overview:
Data source and sink on the far side of the PE-array streaming interface. Stores the query S and target T base sequences loaded by the host, and streams S symbols to the array. Streams T symbols with their V/F boundary scores per pass, and captures the array's T/V/F writeback into a ping-pong buffer that feeds the next pass. Sits between the top-level loader and the PE array controller.

Parameters:
VEF_BIT, 16, width of V/F score values
S_ADDR_BIT, 10, log2 of S storage depth (max S length 1024)
T_ADDR_BIT, 10, log2 of T storage depth and of each writeback bank

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
i_load_valid  in  1  host load strobe (accepted only in IDLE)
i_load_sel  in  1  0 = S symbol, 1 = T symbol
i_load_data  in  2  base code
i_start  in  1  start run (IDLE only)
o_busy  out  1  high from start until END
o_done  out  1  one-cycle pulse at END
o_overrun  out  1  sticky writeback-ordering error
o_data_valid  out  1  current S/T heads valid
i_update_s  in  1  consume S head this cycle
o_s  out  2  S head
o_s_last  out  1  S head is final S symbol
i_update_t  in  1  consume T head this cycle
o_t  out  2  T head
o_v  out  VEF_BIT  V head
o_f  out  VEF_BIT  F head
o_t_last  out  1  T head is last of current pass
i_t_valid  in  1  writeback strobe
i_t  in  2  writeback T
i_v  in  VEF_BIT  writeback V
i_f  in  VEF_BIT  writeback F

Behaviour:
- Reset: state IDLE; all pointers, lengths, and pass counters 0; o_busy, o_done, o_overrun, o_data_valid 0; o_s, o_t, o_v, o_f 0; o_s_last and o_t_last 0.
- Storage: register arrays with asynchronous read. Heads are combinational from registered pointers, so a consume at edge n is visible after edge n.
- IDLE loading:
  - i_load_valid with sel=0 writes S[s_len], s_len++.
  - i_load_valid with sel=1 writes T[t_len], t_len++.
  - Writes beyond depth are dropped and the length saturates.
- IDLE start: i_start with s_len>0 and t_len>0 moves to RUN and sets o_busy the next cycle. Otherwise i_start is ignored.
- RUN and LAST_T states:
  - Consume rule: a pointer advances at the edge where update_x=1 and o_data_valid=1. update_x with o_data_valid=0 is a no-op.
  - o_s_last = (s_ptr == s_len-1).
  - o_t_last = (t_ptr == t_len-1).
  - Consuming o_s_last moves to LAST_T; s_ptr holds.
  - Consuming o_t_last resets t_ptr to 0 and increments rd_pass.
- Pass sources:
  - Pass 0: T from T storage, with v=0 and f=0.
  - Pass k≥1: T/V/F from writeback bank (k-1)&1.
  - o_data_valid: in pass 0, high whenever in RUN or LAST_T. In pass k≥1, high iff (wr_pass > k-1) or (wr_pass == k-1 and wr_cnt > t_ptr); this stalls the reader until the writeback catches up.
- Writeback:
  - i_t_valid writes {i_t, i_v, i_f} to bank wr_pass&1 at wr_cnt, then wr_cnt++.
  - When wr_cnt reaches t_len-1 on a write, wr_cnt goes to 0 and wr_pass increments.
  - i_t_valid when wr_pass > rd_pass sets o_overrun and the write is dropped.
  - i_t_valid in IDLE or END is ignored.
- Simultaneous events:
  - A write and a read of the same bank/address in one cycle: the read returns the old content, and the stall rule already prevents this case.
  - Both updates asserted in one cycle: S and T advance together.
- LAST_T: consuming o_t_last moves to END.
- END: lasts one cycle with o_done=1, then goes to IDLE with o_busy=0.
- Lengths and loaded data are retained for re-runs. A new IDLE load of either sequence (sel) first clears that sequence's length.
- Reset mid-run: returns everything to reset values immediately, including lengths.
- Width rules: pointers and counters are T_ADDR_BIT+1 or S_ADDR_BIT+1 bits. wr_pass and rd_pass are S_ADDR_BIT bits and wrap; comparisons use wrap-safe difference.

Test Plan:
- Load S={0,1,2}, T={3,2,1,0}, start, update_s and update_t held high → S sequence 0,1,2 with o_s_last on 2; T 3,2,1,0 with v=f=0; o_t_last on 0; o_done one cycle after the final T consume.
- Start with t_len=0 → o_busy stays 0 and state stays IDLE.
- Pass 1 with no writeback yet → o_data_valid=0. Write (t=2, v=5, f=3) → next cycle heads are o_t=2, o_v=5, o_f=3, o_data_valid=1.
- T length 4, four writebacks during pass 0 then four more → second group lands in bank 1, wr_pass=2, pass 2 reads bank 1 data.
- i_t_valid while wr_pass > rd_pass → o_overrun=1 (sticky), bank contents unchanged.
- Assert rst_n=0 mid pass 1 → all outputs 0 asynchronously. After release, i_start with lengths 0 is ignored.
